// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: turns one burst command into per-beat native memory-bus
//   requests (incrementing word address, fill data) and per-beat responses.
// Latency: mem_valid rises 1 cycle after command acceptance; each response
//   appears 1 cycle after the mem_ready edge (or the timeout edge).
// Backpressure: cmd_ready only in IDLE; while rsp_valid waits on rsp_ready,
//   the bus stays idle and the next beat is issued only after the handshake.
// Ports:
//   clk, resetn                        - clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb/len - burst command (len = beats-1)
//   mem_valid/instr/addr/wdata/wstrb/ready/rdata - memory-bus initiator side
//   rsp_valid/ready/rdata/err/last     - per-beat response channel
//   busy                               - high whenever a command is in flight
module mem_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEN_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_wstrb,
  input  logic [LEN_W-1:0] cmd_len,

  output logic             mem_valid,
  output logic             mem_instr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_last,

  output logic             busy
);

  // The stall counter only has to reach TIMEOUT_CYCLES-1: the abort is taken
  // on the edge that would have made it TIMEOUT_CYCLES.
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   beats_left;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               cmd_acc;
  logic               beat_done;
  logic               tmo_fire;
  logic               tmo_inc;
  logic               advance;

  // All handshake-facing outputs decode straight from the state register so
  // they drop together, asynchronously, when resetn falls.
  assign cmd_ready = (state == IDLE);
  assign mem_valid = (state == REQ);
  assign rsp_valid = (state == RSP);
  assign busy      = (state != IDLE);
  assign mem_instr = 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_acc   = 1'b0;
    beat_done = 1'b0;
    tmo_fire  = 1'b0;
    tmo_inc   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cmd_acc   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // mem_ready wins over a timeout landing on the same edge.
        if (mem_ready) begin
          beat_done = 1'b1;
          state_nxt = RSP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_fire  = 1'b1;
          state_nxt = RSP;
        end else begin
          tmo_inc   = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          if (rsp_last) begin
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      beats_left <= '0;
      tmo_cnt    <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_last   <= 1'b0;
    end else begin
      if (cmd_acc) begin
        mem_addr   <= {cmd_addr[31:2], 2'b00};
        mem_wdata  <= cmd_wdata;
        mem_wstrb  <= cmd_write ? cmd_wstrb : 4'b0000;
        beats_left <= cmd_len;
        tmo_cnt    <= '0;
      end

      if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      // Read data is captured for writes too; the consumer ignores it.
      if (beat_done) begin
        rsp_rdata <= mem_rdata;
        rsp_err   <= 1'b0;
        rsp_last  <= (beats_left == '0);
      end

      // An aborted beat ends the whole burst: forcing last sends the FSM
      // back to IDLE after this single error response.
      if (tmo_fire) begin
        rsp_rdata  <= '0;
        rsp_err    <= 1'b1;
        rsp_last   <= 1'b1;
        beats_left <= '0;
      end

      // Address wraps naturally modulo 2^32.
      if (advance) begin
        mem_addr   <= mem_addr + 32'd4;
        beats_left <= beats_left - 1'b1;
        tmo_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator: directed bench for mem_bus_initiator with a
// transaction-level model (expected beat and response queues) checked every
// cycle, plus literal expectations per scenario.
module tb_mem_bus_initiator;

  localparam int TMO = 8;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [7:0]  cmd_len;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;

  mem_bus_initiator #(.TIMEOUT_CYCLES(TMO), .LEN_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .cmd_len   (cmd_len),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          last;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          last;
  } rsp_t;

  // Model: a command expands into its beats; each beat becomes a response.
  beat_t       exp_beats[$];
  rsp_t        exp_rsp[$];
  bit          exp_busy;
  int          stall;
  bit          accepted;

  // Observations for the literal per-scenario checks.
  logic [31:0] obs_addr[$];
  logic [3:0]  obs_wstrb[$];
  rsp_t        obs_rsp[$];
  int          obs_mv_cycles;
  int          obs_rv_cycles;

  // Responder knobs.
  int          ready_wait;   // cycles of mem_valid before mem_ready; -1 = silent
  int          rsp_hold;     // cycles rsp_ready stays low per response
  bit          noise;        // drive mem_ready high while mem_valid is low
  int          mv_cnt;
  int          rv_cnt;
  logic [31:0] rd_val;

  int          n_tests;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare();
    beat_t b;
    rsp_t  r;
    bit    on_bus;
    if (!resetn) begin
      exp_beats.delete();
      exp_rsp.delete();
      exp_busy = 1'b0;
      stall    = 0;
      return;
    end
    on_bus = exp_busy && (exp_rsp.size() == 0);
    chk("mem_instr", mem_instr, 0);
    chk("busy", busy, exp_busy);
    chk("cmd_ready", cmd_ready, !exp_busy);
    chk("mem_valid", mem_valid, on_bus);
    chk("rsp_valid", rsp_valid, exp_rsp.size() != 0);
    if (mem_valid) obs_mv_cycles++;
    if (rsp_valid) obs_rv_cycles++;

    if (on_bus && exp_beats.size() > 0) begin
      b = exp_beats[0];
      chk("mem_addr", mem_addr, b.addr);
      chk("mem_wdata", mem_wdata, b.wdata);
      chk("mem_wstrb", mem_wstrb, b.wstrb);
      if (mem_ready) begin
        obs_addr.push_back(mem_addr);
        obs_wstrb.push_back(mem_wstrb);
        r.rdata = mem_rdata;
        r.err   = 1'b0;
        r.last  = b.last;
        exp_rsp.push_back(r);
        void'(exp_beats.pop_front());
        stall = 0;
      end else begin
        stall++;
        if (stall == TMO) begin
          r.rdata = 32'h0;
          r.err   = 1'b1;
          r.last  = 1'b1;
          exp_rsp.push_back(r);
          do b = exp_beats.pop_front(); while (!b.last && exp_beats.size() > 0);
          stall = 0;
        end
      end
    end else if (exp_rsp.size() > 0) begin
      r = exp_rsp[0];
      chk("rsp_rdata", rsp_rdata, r.rdata);
      chk("rsp_err", rsp_err, r.err);
      chk("rsp_last", rsp_last, r.last);
      if (rsp_ready) begin
        r.rdata = rsp_rdata;
        r.err   = rsp_err;
        r.last  = rsp_last;
        obs_rsp.push_back(r);
        void'(exp_rsp.pop_front());
        if (exp_rsp.size() == 0 && exp_beats.size() == 0) exp_busy = 1'b0;
      end
    end else if (!exp_busy && cmd_valid) begin
      for (int i = 0; i <= int'(cmd_len); i++) begin
        b.addr  = {cmd_addr[31:2], 2'b00} + 32'(4 * i);
        b.wdata = cmd_wdata;
        b.wstrb = cmd_write ? cmd_wstrb : 4'h0;
        b.last  = (i == int'(cmd_len));
        exp_beats.push_back(b);
      end
      exp_busy = 1'b1;
      stall    = 0;
      accepted = 1'b1;
    end
  endtask

  task automatic drive();
    if (mem_valid) begin
      if (ready_wait >= 0 && mv_cnt == ready_wait) begin
        mem_ready = 1'b1;
        mem_rdata = rd_val;
        rd_val    = rd_val + 32'h11111111;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
      end
      mv_cnt++;
    end else begin
      mv_cnt    = 0;
      mem_ready = noise;
      mem_rdata = 32'hBAD0BAD0;
    end
    if (rsp_valid) begin
      rsp_ready = (rv_cnt >= rsp_hold);
      rv_cnt++;
    end else begin
      rv_cnt    = 0;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_wstrb.delete();
    obs_rsp.delete();
    obs_mv_cycles = 0;
    obs_rv_cycles = 0;
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [7:0] l);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_len   = l;
    cmd_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) step();
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept: command not accepted within 50 cycles");
    end
    // Scramble the command bus to prove the DUT latched its copy.
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = 32'hFFFF0000;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    cmd_len   = 8'hFF;
  endtask

  task automatic wait_done(input int max_cycles);
    int i;
    i = 0;
    while (exp_busy && i < max_cycles) begin
      step();
      i++;
    end
    if (exp_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: burst still busy after %0d cycles", max_cycles);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;   n_fail = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; cmd_len = 0;
    mem_ready = 0; mem_rdata = 0; rsp_ready = 0;
    ready_wait = 0; rsp_hold = 0; noise = 0; mv_cnt = 0; rv_cnt = 0;
    rd_val = 0; exp_busy = 0; stall = 0; accepted = 0;
    clear_obs();

    // Reset state.
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    resetn = 1'b1;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);

    // Single read, unaligned address, mem_ready 2 cycles after mem_valid.
    clear_obs(); ready_wait = 2; rd_val = 32'hDEADBEEF;
    issue(1'b0, 32'h00001003, 32'h12345678, 4'hF, 8'd0);
    wait_done(100);
    chk("t1_nbeats", obs_addr.size(), 1);
    chk("t1_mv_cycles", obs_mv_cycles, 3);
    chk("t1_nrsp", obs_rsp.size(), 1);
    if (obs_addr.size() == 1) begin
      chk("t1_addr", obs_addr[0], 32'h00001000);
      chk("t1_wstrb", obs_wstrb[0], 4'h0);
    end
    if (obs_rsp.size() == 1) begin
      chk("t1_rdata", obs_rsp[0].rdata, 32'hDEADBEEF);
      chk("t1_err", obs_rsp[0].err, 0);
      chk("t1_last", obs_rsp[0].last, 1);
    end

    // Write fill, zero-wait responder.
    clear_obs(); ready_wait = 0; rd_val = 32'h0;
    issue(1'b1, 32'h00000100, 32'hA5A5A5A5, 4'hF, 8'd3);
    wait_done(100);
    chk("t2_nbeats", obs_addr.size(), 4);
    chk("t2_mv_cycles", obs_mv_cycles, 4);
    chk("t2_nrsp", obs_rsp.size(), 4);
    if (obs_addr.size() == 4 && obs_rsp.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2_addr%0d", i), obs_addr[i], 32'h100 + 32'(4 * i));
        chk($sformatf("t2_wstrb%0d", i), obs_wstrb[i], 4'hF);
        chk($sformatf("t2_last%0d", i), obs_rsp[i].last, (i == 3) ? 1 : 0);
      end
    end

    // Timeout: silent responder on a 3-beat read.
    clear_obs(); ready_wait = -1;
    issue(1'b0, 32'h00000200, 32'h0, 4'h0, 8'd2);
    wait_done(100);
    chk("t3_mv_cycles", obs_mv_cycles, TMO);
    chk("t3_nbeats", obs_addr.size(), 0);
    chk("t3_nrsp", obs_rsp.size(), 1);
    if (obs_rsp.size() == 1) begin
      chk("t3_rdata", obs_rsp[0].rdata, 32'h0);
      chk("t3_err", obs_rsp[0].err, 1);
      chk("t3_last", obs_rsp[0].last, 1);
    end
    chk("t3_idle", cmd_ready, 1);

    // mem_ready on the very edge the timeout would fire: ready wins.
    clear_obs(); ready_wait = TMO - 1; rd_val = 32'hCAFEF00D;
    issue(1'b0, 32'h00000300, 32'h0, 4'h0, 8'd0);
    wait_done(100);
    chk("t3b_mv_cycles", obs_mv_cycles, TMO);
    chk("t3b_nrsp", obs_rsp.size(), 1);
    if (obs_rsp.size() == 1) begin
      chk("t3b_rdata", obs_rsp[0].rdata, 32'hCAFEF00D);
      chk("t3b_err", obs_rsp[0].err, 0);
    end

    // Backpressure: rsp_ready low 5 cycles per response, mem_ready noise
    // while the bus is idle.
    clear_obs(); ready_wait = 1; rsp_hold = 5; noise = 1; rd_val = 32'h11223344;
    issue(1'b0, 32'h00000404, 32'h0, 4'hF, 8'd1);
    wait_done(100);
    noise = 0; rsp_hold = 0;
    chk("t4_mv_cycles", obs_mv_cycles, 4);
    chk("t4_rv_cycles", obs_rv_cycles, 12);
    chk("t4_nrsp", obs_rsp.size(), 2);
    if (obs_addr.size() == 2 && obs_rsp.size() == 2) begin
      chk("t4_addr0", obs_addr[0], 32'h00000404);
      chk("t4_addr1", obs_addr[1], 32'h00000408);
      chk("t4_rdata0", obs_rsp[0].rdata, 32'h11223344);
      chk("t4_rdata1", obs_rsp[1].rdata, 32'h22334455);
      chk("t4_last0", obs_rsp[0].last, 0);
      chk("t4_last1", obs_rsp[1].last, 1);
    end

    // Address wrap at the top of the 32-bit space.
    clear_obs(); ready_wait = 0; rd_val = 32'h0;
    issue(1'b1, 32'hFFFFFFFE, 32'h0BADCAFE, 4'h3, 8'd1);
    wait_done(100);
    chk("t5_nbeats", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      chk("t5_addr0", obs_addr[0], 32'hFFFFFFFC);
      chk("t5_addr1", obs_addr[1], 32'h00000000);
      chk("t5_wstrb1", obs_wstrb[1], 4'h3);
    end

    // Reset asserted mid-REQ, between clock edges.
    clear_obs(); ready_wait = -1;
    issue(1'b1, 32'h00000500, 32'h5A5A5A5A, 4'hC, 8'd0);
    step();
    step();
    chk("t6_mid_req", mem_valid, 1);
    resetn = 1'b0;
    #1;
    chk("t6_mem_valid", mem_valid, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_mem_wstrb", mem_wstrb, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_rdata", rsp_rdata, 0);
    chk("t6_rsp_err", rsp_err, 0);
    chk("t6_rsp_last", rsp_last, 0);
    chk("t6_busy", busy, 0);
    step();
    resetn = 1'b1;
    step();
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_nrsp", obs_rsp.size(), 0);

    // Normal read after reset.
    clear_obs(); ready_wait = 0; rd_val = 32'h600DF00D;
    issue(1'b0, 32'h00000604, 32'h0, 4'h0, 8'd0);
    wait_done(100);
    chk("t7_nrsp", obs_rsp.size(), 1);
    if (obs_rsp.size() == 1) begin
      chk("t7_rdata", obs_rsp[0].rdata, 32'h600DF00D);
      chk("t7_last", obs_rsp[0].last, 1);
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: number of cycles mem_valid may stay high without mem_ready before the beat is aborted.
REQ-002 SHALL have parameter LEN_W, default 8: width of the burst-length field.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when it and cmd_valid are high at a clock edge.
REQ-007 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr, input, 32: start byte address.
REQ-009 SHALL have port cmd_wdata, input, 32: write data, used for every beat of a write burst (fill).
REQ-010 SHALL have port cmd_wstrb, input, 4: byte enables for writes.
REQ-011 SHALL have port cmd_len, input, LEN_W: beat count minus one.
REQ-012 SHALL have ports mem_valid (output, 1), mem_instr (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_wstrb (output, 4), mem_ready (input, 1) and mem_rdata (input, 32), forming the native memory-bus initiator side.
REQ-013 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32), rsp_err (output, 1) and rsp_last (output, 1), forming the per-beat response channel.
REQ-014 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, REQ and RSP; cmd_ready = (state == IDLE).
REQ-016 SHALL, on command acceptance, perform these captures and enter REQ:
- latch mem_addr = {cmd_addr[31:2], 2'b00}
- latch mem_wdata = cmd_wdata
- latch mem_wstrb = cmd_write ? cmd_wstrb : 4'b0000
- latch beats remaining = cmd_len
REQ-017 SHALL drive mem_valid high throughout REQ, starting the cycle after acceptance (1-cycle latency).
REQ-018 SHALL hold mem_addr, mem_wdata and mem_wstrb constant while mem_valid is high.
REQ-019 SHALL tie mem_instr to 0.
REQ-020 SHALL, on a REQ-state edge with mem_ready = 1, perform these actions:
- capture mem_rdata into rsp_rdata (the value is don't-care for writes but still captured)
- set rsp_err = 0
- set rsp_last = (beats remaining == 0)
- enter RSP, so that mem_valid is low the next cycle
REQ-021 SHALL run a timeout counter that clears on entry to REQ and increments on each REQ cycle without mem_ready.
REQ-022 SHALL, when the timeout counter reaches TIMEOUT_CYCLES without mem_ready, perform these actions:
- enter RSP
- set rsp_err = 1, rsp_last = 1 and rsp_rdata = 0
- discard the remaining beats
REQ-023 SHALL give mem_ready priority over timeout when both occur on the same edge.
REQ-024 SHALL hold rsp_valid high throughout RSP, with rsp_rdata, rsp_err and rsp_last stable until rsp_ready is high.
REQ-025 SHALL, on an RSP-state edge with rsp_ready = 1, go to IDLE if rsp_last = 1.
REQ-026 SHALL, on an RSP-state edge with rsp_ready = 1 and rsp_last = 0, advance the burst:
- mem_addr += 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000)
- beats remaining decrements by 1
- re-enter REQ
REQ-027 SHALL ignore mem_ready whenever the state is not REQ.
REQ-028 SHALL keep the bus idle (mem_valid low) while rsp_valid waits on backpressure.

Reset
REQ-029 SHALL, while resetn is low, immediately force these values independent of clk:
- state IDLE
- mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0
- rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_last 0
- busy 0, counters 0
REQ-030 SHALL, on reset asserted during REQ or RSP, abandon the transaction with no response generated and accept a new command only after reset release.

Verification
REQ-031 SHALL be verified by a single read: cmd addr 0x00001003, len 0; mem_ready asserted 2 cycles after mem_valid with rdata 0xDEADBEEF -> mem_addr 0x00001000, mem_wstrb 0, one response with rdata 0xDEADBEEF, err 0, last 1.
REQ-032 SHALL be verified by a write fill: addr 0x100, wdata 0xA5A5A5A5, wstrb 0xF, len 3, zero-wait responder -> four bus beats at 0x100, 0x104, 0x108 and 0x10C with wstrb 0xF, and last 1 on the fourth response only.
REQ-033 SHALL be verified by a timeout: TIMEOUT_CYCLES 8, responder silent, len 2 -> mem_valid low after 8 cycles, single response with err 1, last 1, rdata 0, then IDLE.
REQ-034 SHALL be verified by backpressure: rsp_ready held low 5 cycles on a len 1 read -> mem_valid stays low and rsp fields stay stable, second beat issued only after the handshake.
REQ-035 SHALL be verified by wrap plus reset: addr 0xFFFFFFFC, len 1 -> second beat at 0x00000000; resetn pulsed low mid-REQ -> all outputs 0 asynchronously and cmd_ready 1 after release.
